axi_st_d128_tx_arb: RTL and testbench
=====================================

Name: axi_st_d128_tx_arb

Overview:
Two-source, packet-aware round-robin arbiter that shares the single 128-bit AXI-ST transmit channel of the logic-link master. It sits upstream of the master packing logic. It selects one source, holds the grant until that source's tlast beat is accepted, and drives the packed 145-bit link word (tkeep, tdata, tuser) through a 2-entry skid buffer toward the logic-link TX FIFO.

Parameters:
KEEP_W, 16, tkeep width
DATA_W, 128, tdata width
USER_W, 1, tuser width
LINK_W, 145, packed width = KEEP_W+DATA_W+USER_W (derived, not overridable)

Ports:
clk_wr  in  1  single clock
rst_wr_n  in  1  asynchronous active-low reset
arb_en  in  1  1 = new grants allowed; 0 = finish current packet, then stop granting
s0_tkeep/s1_tkeep  in  16  source keep
s0_tdata/s1_tdata  in  128  source data
s0_tuser/s1_tuser  in  1  source user
s0_tlast/s1_tlast  in  1  end-of-packet marker (not forwarded)
s0_tvalid/s1_tvalid  in  1  source valid
s0_tready/s1_tready  out  1  source ready
user_st_vld  out  1  link word valid
txfifo_st_data  out  145  [0+:16] tkeep, [16+:128] tdata, [144] tuser
user_st_ready  in  1  link accept
grant  out  2  one-hot current owner; 00 = idle
pkt_cnt0/pkt_cnt1  out  16  completed packets per source, wrapping

Behaviour:
- Reset (async assert, sync deassert by the clock domain) clears these to 0: state=IDLE, grant=00, last_owner=1 (so s0 wins first tie), skid buffer empty, user_st_vld=0, txfifo_st_data=0, sN_tready=0, pkt_cnt*=0. Reset mid-packet drops buffered beats; there is no recovery beyond that.
- FSM states IDLE, OWN0, OWN1.
  - IDLE: if arb_en and any sN_tvalid, go to OWNx. On a tie, pick the source != last_owner. The decision registers in 1 cycle, so no beat is accepted in the IDLE cycle.
  - OWNx: sx_tready = !buf_full, where buf_full is registered. The other source's tready = 0.
  - Beat accepted = sx_tvalid & sx_tready. Push {tuser,tdata,tkeep} into the skid buffer.
  - Accepted beat with tlast=1: last_owner<=x, pkt_cntx++, next state IDLE. Re-arbitration happens in the following cycle, so there is one bubble cycle between packets.
  - arb_en low has no effect inside OWNx.
- Skid buffer: 2 entries, FIFO order.
  - user_st_vld = !empty. txfifo_st_data = head entry.
  - Pop on user_st_vld & user_st_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - A push into a full buffer cannot occur, because tready is low when full.
  - Latency from accept to user_st_vld is 1 cycle with an empty buffer.
  - Sustained throughput is 1 beat/cycle when user_st_ready=1.
- While a beat is held (valid & !ready), txfifo_st_data is stable.
- No data-dependent decisions are made on tkeep or tuser.
- pkt counters wrap 0xFFFF -> 0x0000.
- A source deasserting tvalid mid-packet keeps the grant. The arbiter never preempts a packet.

Decomposition:
- Package axi_st_d128_tx_arb_pkg holds:
  - KEEP_W, DATA_W, USER_W, LINK_W localparams
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t
  - packed struct link_word_t {user, data, keep}
- Sub-module axi_st_skid2: generic 2-entry skid buffer parameterized on width. It is reusable on the RX side.

Test Plan:
- Reset with both tvalid=1: after release, grant=01 two cycles later; first word out has keep=FFFF, data=s0 pattern, and user_st_vld arrives 1 cycle after accept.
- Both sources stream 3-beat packets continuously with ready=1: grant alternates 01,10,01; one IDLE bubble between packets; pkt_cnt0=pkt_cnt1=2 after 4 packets.
- user_st_ready held 0 during an s1 packet: two beats buffer, s1_tready falls the cycle after the 2nd accept, and txfifo_st_data holds constant. Release ready and check no loss or reordering.
- arb_en dropped mid s0 packet (beat 2 of 4): beats 3-4 still accepted, then grant=00 with s1_tvalid=1 pending; raise arb_en and s1 is granted next cycle.
- s0 tvalid gap of 5 cycles mid-packet while s1_tvalid=1: grant stays 01 and s1_tready=0 throughout.
- Preload pkt_cnt0 to 0xFFFF via 65535 single-beat packets (or force): the next tlast gives 0x0000. Then assert rst_wr_n=0 mid-beat: all outputs 0 immediately (async).

Source files
------------

// File: rtl/axi_st_d128_tx_arb_pkg.sv
// Shared types and widths for the 128-bit AXI-ST TX arbiter slice.
package axi_st_d128_tx_arb_pkg;

    localparam int KEEP_W = 16;
    localparam int DATA_W = 128;
    localparam int USER_W = 1;
    localparam int LINK_W = KEEP_W + DATA_W + USER_W;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Packed link word: keep in the low bits, user at the top.
    typedef struct packed {
        logic [USER_W-1:0] user;
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
    } link_word_t;

endpackage

// File: rtl/axi_st_d128_tx_arb_if.sv
// One AXI-ST source channel (keep/data/user/last/valid/ready).
interface axi_st_d128_tx_arb_if;
    import axi_st_d128_tx_arb_pkg::*;

    logic [KEEP_W-1:0] tkeep;
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tkeep, tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tkeep, tdata, tuser, tlast, tvalid, output tready);

endinterface

// File: rtl/axi_st_skid2.sv
// Generic 2-entry FIFO-order skid buffer. in_ready depends only on the
// registered occupancy, so out_ready has no combinational path to the producer.
module axi_st_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Entry storage: the tail entry is written on push.
    // NOTE: both entries are reset so the head word reads zero straight out of reset; a deep RAM would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    // NOTE: non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_st_d128_tx_arb.sv
// Two-source packet-aware round-robin arbiter feeding the link TX FIFO through
// a 2-entry skid buffer. A grant is held until the owner's tlast beat is accepted.
module axi_st_d128_tx_arb
    import axi_st_d128_tx_arb_pkg::*;
(
    input  logic                 clk_wr,
    input  logic                 rst_wr_n,
    input  logic                 arb_en,
    axi_st_d128_tx_arb_if.slave  s0,
    axi_st_d128_tx_arb_if.slave  s1,
    output logic                 user_st_vld,
    output logic [LINK_W-1:0]    txfifo_st_data,
    input  logic                 user_st_ready,
    output logic [1:0]           grant,
    output logic [CNT_W-1:0]     pkt_cnt0,
    output logic [CNT_W-1:0]     pkt_cnt1
);
    arb_state_t state;
    arb_state_t state_nxt;
    logic       last_owner;
    logic       buf_ready;
    logic       acc0;
    logic       acc1;
    link_word_t push_word;

    assign acc0 = s0.tvalid & s0.tready;
    assign acc1 = s1.tvalid & s1.tready;

    // State register.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state: arbitrate only from IDLE; leave an owner only on its tlast beat.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arb_en && (s0.tvalid || s1.tvalid)) begin
                    if (s0.tvalid && s1.tvalid) state_nxt = last_owner ? OWN0 : OWN1;
                    else                        state_nxt = s0.tvalid ? OWN0 : OWN1;
                end
            end
            OWN0:    if (acc0 && s0.tlast) state_nxt = IDLE;
            OWN1:    if (acc1 && s1.tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: one-hot grant; only the owner sees ready, gated by buffer space.
    always_comb begin
        grant     = 2'b00;
        s0.tready = 1'b0;
        s1.tready = 1'b0;
        case (state)
            OWN0: begin
                grant     = 2'b01;
                s0.tready = buf_ready;
            end
            OWN1: begin
                grant     = 2'b10;
                s1.tready = buf_ready;
            end
            default: ;
        endcase
    end

    // Owner's beat packed into the link word format; tlast is not forwarded.
    always_comb begin
        push_word = '{user: s0.tuser, data: s0.tdata, keep: s0.tkeep};
        if (state == OWN1) push_word = '{user: s1.tuser, data: s1.tdata, keep: s1.tkeep};
    end

    // Round-robin history and per-source completed-packet counters (wrapping).
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            last_owner <= 1'b1;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
        end else begin
            if (acc0 && s0.tlast) begin
                last_owner <= 1'b0;
                pkt_cnt0   <= pkt_cnt0 + 16'd1;
            end
            if (acc1 && s1.tlast) begin
                last_owner <= 1'b1;
                pkt_cnt1   <= pkt_cnt1 + 16'd1;
            end
        end
    end

    axi_st_skid2 #(
        .WIDTH (LINK_W)
    ) u_skid (
        .clk       (clk_wr),
        .rst_n     (rst_wr_n),
        .in_valid  (acc0 | acc1),
        .in_data   (push_word),
        .in_ready  (buf_ready),
        .out_valid (user_st_vld),
        .out_data  (txfifo_st_data),
        .out_ready (user_st_ready)
    );

endmodule

// File: tb/tb_axi_st_d128_tx_arb.sv
// Bench for axi_st_d128_tx_arb: directed scenarios plus a random phase, every
// cycle compared against a queue-based reference model of the arbiter.
module tb_axi_st_d128_tx_arb;
    import axi_st_d128_tx_arb_pkg::*;

    typedef struct {
        logic [15:0]  keep;
        logic [127:0] data;
        logic         user;
        logic         last;
        int           pre_gap;
    } beat_t;

    logic        clk_wr = 1'b0;
    logic        rst_wr_n;
    logic        arb_en;
    logic        user_st_ready;
    logic        user_st_vld;
    logic [144:0] txfifo_st_data;
    logic [1:0]  grant;
    logic [15:0] pkt_cnt0;
    logic [15:0] pkt_cnt1;

    axi_st_d128_tx_arb_if s0_if ();
    axi_st_d128_tx_arb_if s1_if ();

    axi_st_d128_tx_arb dut (
        .clk_wr         (clk_wr),
        .rst_wr_n       (rst_wr_n),
        .arb_en         (arb_en),
        .s0             (s0_if),
        .s1             (s1_if),
        .user_st_vld    (user_st_vld),
        .txfifo_st_data (txfifo_st_data),
        .user_st_ready  (user_st_ready),
        .grant          (grant),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1)
    );

    always #5 clk_wr = ~clk_wr;

    // Scoreboard counters.
    int n_assert = 0;
    int n_fail   = 0;

    // Source-side stimulus state.
    beat_t src0_q[$];
    beat_t src1_q[$];
    beat_t head[2];
    logic  vld_drv[2];
    bit    pend[2];
    int    gap[2];
    int    pkt_id = 0;
    bit    rnd_valid = 0;
    bit    rnd_ready = 0;
    bit    rnd_arb   = 0;

    // Reference model: owner -1 means nobody holds the channel.
    int          owner = -1;
    int          last_owner = 1;
    link_word_t  mq[$];
    logic [15:0] cnt[2];

    // Grant history for the alternation scenario.
    bit          log_grant = 0;
    logic [1:0]  gprev = 2'b00;
    logic [1:0]  glog[$];

    task automatic check(input string tag, input logic [144:0] obs, input logic [144:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int nb, input bit rnd, input int gap_at, input int gap_len);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.keep    = rnd ? 16'($urandom) : 16'hFFFF;
            b.data    = {s[3:0], pkt_id[11:0], i[15:0], $urandom, $urandom, $urandom};
            b.user    = rnd ? 1'($urandom) : 1'b0;
            b.last    = (i == nb - 1);
            b.pre_gap = (i == gap_at) ? gap_len : 0;
            if (s == 0) src0_q.push_back(b);
            else        src1_q.push_back(b);
        end
        pkt_id++;
    endtask

    // Present source beats; a valid that was not accepted stays up unchanged.
    task automatic drive();
        int n;
        for (int s = 0; s < 2; s++) begin
            n = (s == 0) ? src0_q.size() : src1_q.size();
            if (n > 0) head[s] = (s == 0) ? src0_q[0] : src1_q[0];
            if (pend[s])          vld_drv[s] = 1'b1;
            else if (n == 0)      vld_drv[s] = 1'b0;
            else if (gap[s] > 0) begin
                vld_drv[s] = 1'b0;
                gap[s]--;
            end
            else vld_drv[s] = rnd_valid ? ($urandom_range(0, 99) < 70) : 1'b1;
        end
        if (rnd_ready) user_st_ready = ($urandom_range(0, 99) < 70);
        if (rnd_arb)   arb_en = ($urandom_range(0, 99) < 90);
        s0_if.tkeep  = head[0].keep;
        s0_if.tdata  = head[0].data;
        s0_if.tuser  = head[0].user;
        s0_if.tlast  = head[0].last;
        s0_if.tvalid = vld_drv[0];
        s1_if.tkeep  = head[1].keep;
        s1_if.tdata  = head[1].data;
        s1_if.tuser  = head[1].user;
        s1_if.tlast  = head[1].last;
        s1_if.tvalid = vld_drv[1];
    endtask

    // One clock: drive at the falling edge, compare, then advance the model at the rising edge.
    task automatic cycle();
        logic [1:0] g_exp;
        int         acc;
        bit         pop;
        link_word_t w;
        drive();
        #1;
        g_exp = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        check("grant", grant, g_exp);
        check("s0_tready", s0_if.tready, (owner == 0) && (mq.size() < 2));
        check("s1_tready", s1_if.tready, (owner == 1) && (mq.size() < 2));
        check("user_st_vld", user_st_vld, mq.size() != 0);
        if (mq.size() != 0) check("txfifo_st_data", txfifo_st_data, mq[0]);
        check("pkt_cnt0", pkt_cnt0, cnt[0]);
        check("pkt_cnt1", pkt_cnt1, cnt[1]);
        if (log_grant && grant != 2'b00 && grant != gprev) glog.push_back(grant);
        gprev = grant;
        @(posedge clk_wr);
        if (rst_wr_n) begin
            acc = -1;
            pop = (mq.size() != 0) && user_st_ready;
            if (owner >= 0 && vld_drv[owner] && mq.size() < 2) acc = owner;
            if (pop) void'(mq.pop_front());
            if (acc >= 0) begin
                w.user = head[acc].user;
                w.data = head[acc].data;
                w.keep = head[acc].keep;
                mq.push_back(w);
                if (acc == 0) begin
                    void'(src0_q.pop_front());
                    gap[0] = (src0_q.size() > 0) ? src0_q[0].pre_gap : 0;
                end else begin
                    void'(src1_q.pop_front());
                    gap[1] = (src1_q.size() > 0) ? src1_q[0].pre_gap : 0;
                end
                if (head[acc].last) begin
                    last_owner = acc;
                    cnt[acc]   = cnt[acc] + 16'd1;
                    owner      = -1;
                end
            end else if (owner < 0 && arb_en && (vld_drv[0] || vld_drv[1])) begin
                if (vld_drv[0] && vld_drv[1]) owner = 1 - last_owner;
                else                          owner = vld_drv[0] ? 0 : 1;
            end
            for (int s = 0; s < 2; s++) pend[s] = vld_drv[s] && (acc != s);
        end
        @(negedge clk_wr);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n = 0;
        while ((src0_q.size() != 0 || src1_q.size() != 0 || mq.size() != 0 || owner >= 0) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_drain"}, (n < budget), 1'b1);
    endtask

    initial begin
        logic [144:0] t1_word;
        logic [1:0]   gexp [4];
        gexp = '{2'b01, 2'b10, 2'b01, 2'b10};
        head[0] = '{default: 0};
        head[1] = '{default: 0};
        vld_drv = '{1'b0, 1'b0};
        pend    = '{0, 0};
        gap     = '{0, 0};
        cnt     = '{16'h0, 16'h0};
        rst_wr_n      = 1'b0;
        arb_en        = 1'b1;
        user_st_ready = 1'b1;

        // Reset with both sources offering 3-beat packets (2 each).
        add_pkt(0, 3, 0, -1, 0);
        add_pkt(1, 3, 0, -1, 0);
        add_pkt(0, 3, 0, -1, 0);
        add_pkt(1, 3, 0, -1, 0);
        t1_word = {1'b0, src0_q[0].data, 16'hFFFF};
        @(negedge clk_wr);
        run_cycles(2);
        check("rst_data", txfifo_st_data, '0);
        rst_wr_n  = 1'b1;
        log_grant = 1;
        run_cycles(2);
        check("t1_vld_after_accept", user_st_vld, 1'b1);
        check("t1_first_word", txfifo_st_data, t1_word);
        run_until_idle(200, "t2");
        log_grant = 0;
        check("t2_pkt_cnt0", pkt_cnt0, 16'd2);
        check("t2_pkt_cnt1", pkt_cnt1, 16'd2);
        check("t2_grant_changes", glog.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < glog.size()) check("t2_grant_seq", glog[i], gexp[i]);

        // Link stalled during an s1 packet: two beats buffer, then ready drops.
        user_st_ready = 1'b0;
        add_pkt(1, 4, 1, -1, 0);
        run_cycles(8);
        check("t3_s1_tready_low", s1_if.tready, 1'b0);
        check("t3_vld_held", user_st_vld, 1'b1);
        user_st_ready = 1'b1;
        run_until_idle(100, "t3");

        // arb_en dropped after beat 2 of a 4-beat s0 packet, s1 waiting.
        add_pkt(0, 4, 1, -1, 0);
        add_pkt(1, 2, 1, -1, 0);
        run_cycles(3);
        arb_en = 1'b0;
        run_cycles(6);
        check("t4_grant_idle", grant, 2'b00);
        check("t4_s1_waiting", s1_if.tvalid, 1'b1);
        arb_en = 1'b1;
        run_cycles(1);
        #1;
        check("t4_grant_s1", grant, 2'b10);
        run_until_idle(100, "t4");

        // 5-cycle tvalid gap inside an s0 packet while s1 is pending.
        add_pkt(0, 4, 0, 2, 5);
        add_pkt(1, 2, 1, -1, 0);
        run_cycles(8);
        check("t5_grant_held", grant, 2'b01);
        check("t5_s1_tready", s1_if.tready, 1'b0);
        run_until_idle(100, "t5");

        // Random traffic, gaps, backpressure and arb_en toggling.
        rnd_valid = 1;
        rnd_ready = 1;
        rnd_arb   = 1;
        for (int i = 0; i < 300; i++)
            add_pkt(i % 2, $urandom_range(1, 6), 1, $urandom_range(0, 5), $urandom_range(0, 3));
        run_until_idle(20000, "rnd");
        rnd_valid     = 0;
        rnd_ready     = 0;
        rnd_arb       = 0;
        arb_en        = 1'b1;
        user_st_ready = 1'b1;
        run_cycles(2);

        // Counter wrap: preload 0xFFFF, one more single-beat packet gives 0.
        force dut.pkt_cnt0 = 16'hFFFF;
        #1;
        release dut.pkt_cnt0;
        cnt[0] = 16'hFFFF;
        add_pkt(0, 1, 1, -1, 0);
        run_until_idle(50, "wrap");
        check("t6_wrap", pkt_cnt0, 16'h0000);

        // Async reset in the middle of a buffered s1 packet.
        user_st_ready = 1'b0;
        add_pkt(1, 4, 1, -1, 0);
        run_cycles(4);
        @(posedge clk_wr);
        #2;
        rst_wr_n = 1'b0;
        #1;
        check("t7_grant", grant, 2'b00);
        check("t7_s0_tready", s0_if.tready, 1'b0);
        check("t7_s1_tready", s1_if.tready, 1'b0);
        check("t7_vld", user_st_vld, 1'b0);
        check("t7_data", txfifo_st_data, '0);
        check("t7_pkt_cnt0", pkt_cnt0, 16'h0);
        check("t7_pkt_cnt1", pkt_cnt1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
